// File: rtl/accumulator_pkg.sv
// Shared constants and helpers for the multi-channel accumulator and its edge detector.
package accumulator_pkg;

    localparam bit ACC_MODE_WRAP = 1'b0;
    localparam bit ACC_MODE_SAT  = 1'b1;

    // A single channel still needs a 1-bit select port.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rising_edge_shot.sv
// Registered rising-edge detector: one-cycle shot the edge after level goes 0 -> 1.
module rising_edge_shot (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic shot
);

    logic hist;

    // History resets to 0, so a level already high at reset release yields one shot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= 1'b0;
            shot <= 1'b0;
        end else begin
            hist <= level;
            shot <= level & ~hist;
        end
    end

endmodule

// File: rtl/accumulator_multichannel.sv
// CHANNELS independent running sums, one add per enable rising edge, with
// wrap/saturate overflow, per-channel clear, sticky overflow flags and a registered read port.
module accumulator_multichannel
    import accumulator_pkg::*;
#(
    parameter int WORD_LENGTH = 8,
    parameter int ACC_LENGTH  = 12,
    parameter int CHANNELS    = 4,
    parameter bit SATURATE    = ACC_MODE_SAT,
    localparam int CH_W       = ch_width(CHANNELS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [CH_W-1:0]        channel,
    input  logic [WORD_LENGTH-1:0] Data_Input,
    input  logic                   clear,
    input  logic                   Read,
    output logic [ACC_LENGTH-1:0]  Data_Output,
    output logic                   Data_Valid,
    output logic [CHANNELS-1:0]    Overflow
);

    logic                   shot;
    logic [CH_W-1:0]        pend_ch;
    logic [WORD_LENGTH-1:0] pend_data;
    logic [ACC_LENGTH-1:0]  acc [CHANNELS];
    logic [ACC_LENGTH-1:0]  acc_sel;
    logic [ACC_LENGTH-1:0]  rd_sel;
    logic [ACC_LENGTH-1:0]  add_result;
    logic [ACC_LENGTH:0]    sum;
    logic                   add_carry;

    rising_edge_shot u_shot (
        .clk   (clk),
        .reset (reset),
        .level (enable),
        .shot  (shot)
    );

    // Capturing every cycle is enough: the shot is only ever paired with the
    // operands sampled on the same edge that produced it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_ch   <= '0;
            pend_data <= '0;
        end else begin
            pend_ch   <= channel;
            pend_data <= Data_Input;
        end
    end

    // Out-of-range selects match no channel, so the add mux and read mux both fall back to 0.
    always_comb begin
        acc_sel = '0;
        rd_sel  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (pend_ch == CH_W'(i)) acc_sel = acc[i];
            if (channel == CH_W'(i)) rd_sel  = acc[i];
        end
        sum       = {1'b0, acc_sel} + (ACC_LENGTH+1)'(pend_data);
        add_carry = sum[ACC_LENGTH];
        if (add_carry && (SATURATE == ACC_MODE_SAT)) add_result = '1;
        else                                         add_result = sum[ACC_LENGTH-1:0];
    end

    // Clear has priority over a pending add to the same channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
            Overflow <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (clear && (channel == CH_W'(i))) begin
                    acc[i]      <= '0;
                    Overflow[i] <= 1'b0;
                end else if (shot && (pend_ch == CH_W'(i))) begin
                    acc[i] <= add_result;
                    if (add_carry) Overflow[i] <= 1'b1;
                end
            end
        end
    end

    // Read/Data_Valid: a Read sampled at an edge strobes Data_Valid for the next
    // cycle with Data_Output holding the pre-update value; there is no back-pressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Data_Output <= '0;
            Data_Valid  <= 1'b0;
        end else begin
            Data_Valid <= Read;
            if (Read) Data_Output <= rd_sel;
        end
    end

endmodule

// File: tb/tb_accumulator_multichannel.sv
// Directed bench: instance a (saturate, 4 channels) and instance b (wrap, 3 channels).
module tb_accumulator_multichannel;

    logic        clk = 1'b0;
    logic        reset;

    logic        en_a, clr_a, rd_a, dv_a;
    logic [1:0]  ch_a;
    logic [7:0]  din_a;
    logic [11:0] dout_a;
    logic [3:0]  ovf_a;

    logic        en_b, clr_b, rd_b, dv_b;
    logic [1:0]  ch_b;
    logic [7:0]  din_b;
    logic [11:0] dout_b;
    logic [2:0]  ovf_b;

    logic [11:0] exp_q_a[$];
    logic [11:0] exp_q_b[$];

    int n_checks = 0;
    int n_pass   = 0;

    accumulator_multichannel #(.WORD_LENGTH(8), .ACC_LENGTH(12), .CHANNELS(4), .SATURATE(1'b1)) dut_a (
        .clk(clk), .reset(reset), .enable(en_a), .channel(ch_a), .Data_Input(din_a),
        .clear(clr_a), .Read(rd_a), .Data_Output(dout_a), .Data_Valid(dv_a), .Overflow(ovf_a)
    );

    accumulator_multichannel #(.WORD_LENGTH(8), .ACC_LENGTH(12), .CHANNELS(3), .SATURATE(1'b0)) dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .channel(ch_b), .Data_Input(din_b),
        .clear(clr_b), .Read(rd_b), .Data_Output(dout_b), .Data_Valid(dv_b), .Overflow(ovf_b)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Scoreboard monitors: pop one expected value per Data_Valid strobe.
    always @(negedge clk) begin
        if (!reset && dv_a) begin
            if (exp_q_a.size() == 0) check("unexpected_valid_a", 1, 0);
            else check("read_a", int'(dout_a), int'(exp_q_a.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (!reset && dv_b) begin
            if (exp_q_b.size() == 0) check("unexpected_valid_b", 1, 0);
            else check("read_b", int'(dout_b), int'(exp_q_b.pop_front()));
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit sel, input logic en, input logic [1:0] ch,
                          input logic [7:0] d, input logic clr, input logic rd);
        if (!sel) begin
            en_a = en; ch_a = ch; din_a = d; clr_a = clr; rd_a = rd;
        end else begin
            en_b = en; ch_b = ch; din_b = d; clr_b = clr; rd_b = rd;
        end
    endtask

    task automatic pulse_add(input bit sel, input logic [1:0] ch, input logic [7:0] d);
        set_in(sel, 1'b1, ch, d, 1'b0, 1'b0);
        step();
        set_in(sel, 1'b0, ch, d, 1'b0, 1'b0);
        step();
    endtask

    task automatic do_read(input bit sel, input logic [1:0] ch, input logic [11:0] exp);
        if (!sel) exp_q_a.push_back(exp);
        else      exp_q_b.push_back(exp);
        set_in(sel, 1'b0, ch, 8'd0, 1'b0, 1'b1);
        step();
        set_in(sel, 1'b0, ch, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic do_clear(input bit sel, input logic [1:0] ch);
        set_in(sel, 1'b0, ch, 8'd0, 1'b1, 1'b0);
        step();
        set_in(sel, 1'b0, ch, 8'd0, 1'b0, 1'b0);
    endtask

    // Brings a channel from 0 to 4090 (16 * 255 + 10).
    task automatic preload_4090(input bit sel, input logic [1:0] ch);
        for (int i = 0; i < 16; i++) pulse_add(sel, ch, 8'd255);
        pulse_add(sel, ch, 8'd10);
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
        repeat (3) step();
        check("reset_dout_a", int'(dout_a), 0);
        check("reset_valid_a", int'(dv_a), 0);
        check("reset_ovf_a", int'(ovf_a), 0);
        reset = 1'b0;
        step();

        // Basic add and read
        do_read(1'b0, 2'd0, 12'd0);
        pulse_add(1'b0, 2'd0, 8'd5);
        do_read(1'b0, 2'd0, 12'd5);
        step();
        check("ovf_a_after_add", int'(ovf_a), 0);

        // Saturation on ch1
        preload_4090(1'b0, 2'd1);
        do_read(1'b0, 2'd1, 12'd4090);
        check("ovf_a_preload", int'(ovf_a), 0);
        pulse_add(1'b0, 2'd1, 8'd10);
        do_read(1'b0, 2'd1, 12'd4095);
        check("ovf_a_sat", int'(ovf_a), 4'b0010);
        pulse_add(1'b0, 2'd1, 8'd0);
        do_read(1'b0, 2'd1, 12'd4095);

        // Read on the edge the add executes returns the pre-update value; held Read re-strobes
        set_in(1'b0, 1'b1, 2'd0, 8'd2, 1'b0, 1'b0);
        step();
        exp_q_a.push_back(12'd5);
        set_in(1'b0, 1'b0, 2'd0, 8'd2, 1'b0, 1'b1);
        step();
        exp_q_a.push_back(12'd7);
        step();
        set_in(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);

        // Clear and pending add on the same channel: clear wins
        pulse_add(1'b0, 2'd3, 8'd7);
        do_read(1'b0, 2'd3, 12'd7);
        set_in(1'b0, 1'b1, 2'd3, 8'd3, 1'b0, 1'b0);
        step();
        set_in(1'b0, 1'b0, 2'd3, 8'd0, 1'b1, 1'b0);
        step();
        set_in(1'b0, 1'b0, 2'd3, 8'd0, 1'b0, 1'b0);
        do_read(1'b0, 2'd3, 12'd0);

        // Clear ch3 while the pending add lands on ch0: both happen
        pulse_add(1'b0, 2'd3, 8'd3);
        set_in(1'b0, 1'b1, 2'd0, 8'd4, 1'b0, 1'b0);
        step();
        set_in(1'b0, 1'b0, 2'd3, 8'd0, 1'b1, 1'b0);
        step();
        set_in(1'b0, 1'b0, 2'd3, 8'd0, 1'b0, 1'b0);
        do_read(1'b0, 2'd0, 12'd11);
        do_read(1'b0, 2'd3, 12'd0);
        check("ovf_a_after_clear3", int'(ovf_a), 4'b0010);

        // Enable held high for 10 cycles: exactly one add
        set_in(1'b0, 1'b1, 2'd2, 8'd6, 1'b0, 1'b0);
        repeat (10) step();
        set_in(1'b0, 1'b0, 2'd2, 8'd6, 1'b0, 1'b0);
        repeat (2) step();
        do_read(1'b0, 2'd2, 12'd6);
        step();

        // Reset between shot and add discards the add; enable high through release counts once
        set_in(1'b0, 1'b1, 2'd2, 8'd9, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        set_in(1'b0, 1'b1, 2'd1, 8'd3, 1'b0, 1'b0);
        #1;
        check("async_reset_dout_a", int'(dout_a), 0);
        check("async_reset_valid_a", int'(dv_a), 0);
        check("async_reset_ovf_a", int'(ovf_a), 0);
        repeat (2) step();
        reset = 1'b0;
        step();
        set_in(1'b0, 1'b0, 2'd1, 8'd3, 1'b0, 1'b0);
        step();
        do_read(1'b0, 2'd2, 12'd0);
        do_read(1'b0, 2'd1, 12'd3);
        do_read(1'b0, 2'd0, 12'd0);

        // Wrap mode on instance b
        preload_4090(1'b1, 2'd1);
        pulse_add(1'b1, 2'd1, 8'd10);
        do_read(1'b1, 2'd1, 12'd4);
        step();
        check("ovf_b_ch1", int'(ovf_b), 3'b010);
        preload_4090(1'b1, 2'd2);
        pulse_add(1'b1, 2'd2, 8'd10);
        do_read(1'b1, 2'd2, 12'd4);
        step();
        check("ovf_b_ch2", int'(ovf_b), 3'b110);
        do_clear(1'b1, 2'd2);
        check("ovf_b_clear2", int'(ovf_b), 3'b010);
        do_read(1'b1, 2'd2, 12'd0);

        // Out-of-range channel 3 on the 3-channel instance
        pulse_add(1'b1, 2'd3, 8'd50);
        do_read(1'b1, 2'd3, 12'd0);
        do_clear(1'b1, 2'd3);
        check("ovf_b_oor_clear", int'(ovf_b), 3'b010);
        do_read(1'b1, 2'd1, 12'd4);
        do_read(1'b1, 2'd0, 12'd0);

        repeat (3) step();
        check("exp_q_a_drained", exp_q_a.size(), 0);
        check("exp_q_b_drained", exp_q_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
